psum_drain: RTL and testbench

Post-processing drain stage downstream of the psum GLB. After a layer completes, it streams every accumulated partial sum out of the psum GLB read port and adds the per-channel bias fetched from the bias GLB. It saturates each result to 16 bits, optionally applies ReLU, and packs four results per 64-bit word into the output (ofmap/DRAM) FIFO under full-flag backpressure.

---
 rtl/psum_drain.sv | 187 ++++++++++++++++++
 tb/tb_psum_drain.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// Drains the psum GLB after a layer, adds per-channel bias, saturates, packs four results per FIFO word.
// Optional RELU_EN: clamp negative results to zero before packing.
module psum_drain #(
    parameter int FIFO_WIDTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_psum  = 18,
    parameter int ADDR_bias  = 9
) (
    input  logic                  core_clk,
    input  logic                  core_rst_n,
    input  logic                  start,
    input  logic [ADDR_bias-1:0]  num_ch,
    input  logic [ADDR_psum-1:0]  ch_size,
    output logic                  re_b_psum,
    output logic [ADDR_psum-1:0]  addr_b_psum,
    input  logic [DATA_WIDTH-1:0] rdata_b_psum,
    output logic                  re_bias,
    output logic [ADDR_bias-1:0]  raddr_bias,
    input  logic [DATA_WIDTH-1:0] rdata_bias,
    output logic [FIFO_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_we,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, BIAS_RD, BIAS_WAIT, STREAM, FLUSH, FIN} state_t;

    state_t                state;
    logic [ADDR_bias-1:0]  num_ch_r;
    logic [ADDR_bias-1:0]  ch_idx;
    logic [ADDR_psum-1:0]  ch_size_r;
    logic [ADDR_psum-1:0]  elem_cnt;
    logic [DATA_WIDTH-1:0] bias_r;
    logic                  inflight;
    logic [1:0]            lanes_filled;
    logic [FIFO_WIDTH-1:0] lane_word;
    logic                  out_pending;

    logic                  can_issue;
    logic                  last_in_ch;
    logic                  last_ch;
    logic                  fill_word;
    logic                  flush_move;
    logic                  flush_done;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] result;

    assign fifo_we = out_pending & ~fifo_full;

    // While a full word waits for the FIFO, only issue reads that the three free lanes can absorb.
    always_comb begin
        can_issue  = !out_pending || (({1'b0, lanes_filled} + {2'b00, inflight}) <= 3'd2);
        re_b_psum  = (state == STREAM) && can_issue;
        last_in_ch = (elem_cnt == (ch_size_r - ADDR_psum'(1)));
        last_ch    = (ch_idx == (num_ch_r - ADDR_bias'(1)));
        fill_word  = inflight && (lanes_filled == 2'd3);
        flush_move = (state == FLUSH) && !inflight && (lanes_filled != 2'd0)
                     && (!out_pending || fifo_we);
        flush_done = (state == FLUSH) && !inflight && (lanes_filled == 2'd0)
                     && (!out_pending || fifo_we);
    end

    always_comb begin
        sum_ext = {rdata_b_psum[DATA_WIDTH-1], rdata_b_psum} + {bias_r[DATA_WIDTH-1], bias_r};
        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            result = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            result = sum_ext[DATA_WIDTH-1:0];
        end
`ifdef RELU_EN
        if (result[DATA_WIDTH-1]) begin
            result = '0;
        end
`endif
    end

    // An empty job enters FIN with done low; FIN raises done on its first cycle and exits on the second.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state       <= IDLE;
            num_ch_r    <= '0;
            ch_size_r   <= '0;
            ch_idx      <= '0;
            elem_cnt    <= '0;
            addr_b_psum <= '0;
            re_bias     <= 1'b0;
            raddr_bias  <= '0;
            bias_r      <= '0;
            inflight    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            re_bias  <= 1'b0;
            inflight <= re_b_psum;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_ch_r    <= num_ch;
                        ch_size_r   <= ch_size;
                        ch_idx      <= '0;
                        elem_cnt    <= '0;
                        addr_b_psum <= '0;
                        raddr_bias  <= '0;
                        busy        <= 1'b1;
                        if ((num_ch == '0) || (ch_size == '0)) begin
                            state <= FIN;
                        end else begin
                            re_bias <= 1'b1;
                            state   <= BIAS_RD;
                        end
                    end
                end
                BIAS_RD: state <= BIAS_WAIT;
                BIAS_WAIT: begin
                    bias_r <= rdata_bias;
                    state  <= STREAM;
                end
                STREAM: begin
                    if (re_b_psum) begin
                        addr_b_psum <= addr_b_psum + ADDR_psum'(1);
                        if (last_in_ch) begin
                            elem_cnt <= '0;
                            if (last_ch) begin
                                state <= FLUSH;
                            end else begin
                                ch_idx     <= ch_idx + ADDR_bias'(1);
                                raddr_bias <= ch_idx + ADDR_bias'(1);
                                re_bias    <= 1'b1;
                                state      <= BIAS_RD;
                            end
                        end else begin
                            elem_cnt <= elem_cnt + ADDR_psum'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane packing: a completed word moves to the output register, which stays frozen until written.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            lanes_filled <= 2'd0;
            lane_word    <= '0;
            fifo_wdata   <= '0;
            out_pending  <= 1'b0;
        end else if (fill_word) begin
            fifo_wdata   <= {result, lane_word[FIFO_WIDTH-DATA_WIDTH-1:0]};
            lane_word    <= '0;
            lanes_filled <= 2'd0;
            out_pending  <= 1'b1;
        end else begin
            if (inflight) begin
                lane_word[lanes_filled*DATA_WIDTH +: DATA_WIDTH] <= result;
                lanes_filled <= lanes_filled + 2'd1;
            end
            if (flush_move) begin
                fifo_wdata   <= lane_word;
                lane_word    <= '0;
                lanes_filled <= 2'd0;
                out_pending  <= 1'b1;
            end else if (fifo_we) begin
                out_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: GLB read models, FIFO write monitor, hand-computed expected words and cycles.
module tb_psum_drain;

    logic        core_clk = 1'b0;
    logic        core_rst_n;
    logic        start;
    logic [8:0]  num_ch;
    logic [17:0] ch_size;
    logic        re_b_psum;
    logic [17:0] addr_b_psum;
    logic [15:0] rdata_b_psum = 16'h0;
    logic        re_bias;
    logic [8:0]  raddr_bias;
    logic [15:0] rdata_bias = 16'h0;
    logic [63:0] fifo_wdata;
    logic        fifo_we;
    logic        fifo_full;
    logic        busy;
    logic        done;

    psum_drain dut (
        .core_clk     (core_clk),
        .core_rst_n   (core_rst_n),
        .start        (start),
        .num_ch       (num_ch),
        .ch_size      (ch_size),
        .re_b_psum    (re_b_psum),
        .addr_b_psum  (addr_b_psum),
        .rdata_b_psum (rdata_b_psum),
        .re_bias      (re_bias),
        .raddr_bias   (raddr_bias),
        .rdata_bias   (rdata_bias),
        .fifo_wdata   (fifo_wdata),
        .fifo_we      (fifo_we),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .done         (done)
    );

    always #5 core_clk = ~core_clk;

    logic [15:0] psum_mem [64];
    logic [15:0] bias_mem [8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rel;

    logic [63:0] wq [$];
    int          wcyc [$];
    int          bq [$];
    int          rd_cnt, rb_first, rp_first, done_cyc, done_cnt;
    int          busy_cyc, busy_err, full_we_err, rd_at24;

    always @(posedge core_clk) cyc <= cyc + 1;

    // One-cycle read latency GLB models
    always @(posedge core_clk) begin
        if (re_b_psum) rdata_b_psum <= psum_mem[addr_b_psum[5:0]];
        if (re_bias)   rdata_bias   <= bias_mem[raddr_bias[2:0]];
    end

    // Monitor samples on the falling edge, cycle numbers relative to the start cycle
    always @(negedge core_clk) begin
        if (core_rst_n) begin
            rel = cyc - start_cyc;
            if (fifo_we) begin
                wq.push_back(fifo_wdata);
                wcyc.push_back(rel);
                if (fifo_full) full_we_err++;
            end
            if (re_bias) begin
                bq.push_back(int'(raddr_bias));
                if (rb_first < 0) rb_first = rel;
            end
            if (re_b_psum) begin
                rd_cnt++;
                if (rp_first < 0) rp_first = rel;
            end
            if (rel == 24) rd_at24 = rd_cnt;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = rel;
                if (busy) busy_err++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wordAt(input int i);
        return (i < wq.size()) ? wq[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic int cycAt(input int i);
        return (i < wcyc.size()) ? wcyc[i] : -1;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wdata"}, fifo_wdata, 64'h0);
        checkOutput({tag, "_ctl"}, 64'({re_b_psum, addr_b_psum, re_bias, raddr_bias, fifo_we, busy, done}), 64'h0);
    endtask

    // Runs one job; fifo_full is high for cycles [full_from, full_from+full_len); rst_at>0 aborts with reset
    task automatic applyStimulus(input int nch, input int csz, input int full_from,
                                 input int full_len, input int rst_at);
        wq.delete(); wcyc.delete(); bq.delete();
        rd_cnt = 0; rb_first = -1; rp_first = -1; done_cyc = -1; done_cnt = 0;
        busy_cyc = 0; busy_err = 0; full_we_err = 0; rd_at24 = -1;
        @(posedge core_clk); #1;
        start_cyc = cyc;
        num_ch    = 9'(nch);
        ch_size   = 18'(csz);
        start     = 1'b1;
        for (int i = 1; i < 300; i++) begin
            @(posedge core_clk); #1;
            start     = 1'b0;
            fifo_full = (i >= full_from) && (i < full_from + full_len);
            if (i == rst_at) begin
                core_rst_n = 1'b0;
                #1;
                checkResetOutputs("midrun_reset");
                repeat (2) @(posedge core_clk);
                #1;
                core_rst_n = 1'b1;
                repeat (5) @(posedge core_clk);
                #1;
                break;
            end
            if (done_cnt != 0) begin
                repeat (3) @(posedge core_clk);
                #1;
                break;
            end
        end
        fifo_full = 1'b0;
    endtask

    task automatic loadCase2();
        for (int i = 0; i < 6; i++) psum_mem[i] = 16'(i);
        bias_mem[0] = 16'd100;
        bias_mem[1] = 16'hFFFF;
    endtask

    task automatic checkCase2(input string tag);
        checkOutput({tag, "_nwrites"}, 64'(wq.size()), 64'd2);
        checkOutput({tag, "_word0"}, wordAt(0), 64'h0002_0066_0065_0064);
        checkOutput({tag, "_word1"}, wordAt(1), 64'h0000_0000_0004_0003);
        checkOutput({tag, "_bias_rds"}, 64'(bq.size()), 64'd2);
        checkOutput({tag, "_bias_addr1"}, 64'((bq.size() > 1) ? bq[1] : -1), 64'd1);
        checkOutput({tag, "_wcyc0"}, 64'(cycAt(0)), 64'd10);
        checkOutput({tag, "_wcyc1"}, 64'(cycAt(1)), 64'd13);
        checkOutput({tag, "_done_cyc"}, 64'(done_cyc), 64'd14);
        checkOutput({tag, "_psum_rds"}, 64'(rd_cnt), 64'd6);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) psum_mem[i] = 16'h0;
        for (int i = 0; i < 8; i++) bias_mem[i] = 16'h0;
        core_rst_n = 1'b0;
        start      = 1'b0;
        fifo_full  = 1'b0;
        num_ch     = '0;
        ch_size    = '0;
        repeat (3) @(posedge core_clk);
        #1;
        checkResetOutputs("reset");
        core_rst_n = 1'b1;

        // Case 1: single word, basic timing
        psum_mem[0] = 16'd1; psum_mem[1] = 16'd2; psum_mem[2] = 16'd3; psum_mem[3] = 16'd4;
        bias_mem[0] = 16'd10;
        applyStimulus(1, 4, 1000, 0, -1);
        checkOutput("c1_nwrites", 64'(wq.size()), 64'd1);
        checkOutput("c1_word", wordAt(0), 64'h000E_000D_000C_000B);
        checkOutput("c1_wcyc", 64'(cycAt(0)), 64'd8);
        checkOutput("c1_done_cyc", 64'(done_cyc), 64'd9);
        checkOutput("c1_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("c1_bias_rd_cyc", 64'(rb_first), 64'd1);
        checkOutput("c1_psum_rd_cyc", 64'(rp_first), 64'd3);
        checkOutput("c1_busy_cycles", 64'(busy_cyc), 64'd8);
        checkOutput("c1_busy_at_done", 64'(busy_err), 64'd0);

        // Case 2: channel change, stale bias on boundary element, partial flush
        loadCase2();
        applyStimulus(2, 3, 1000, 0, -1);
        checkCase2("c2");
        checkOutput("c2_bias_addr0", 64'((bq.size() > 0) ? bq[0] : -1), 64'd0);

        // Case 3: saturation at both rails, negative results
        psum_mem[0] = 16'd32000; psum_mem[1] = 16'hFFFB;
        psum_mem[2] = 16'h8300;  psum_mem[3] = 16'd300;
        bias_mem[0] = 16'd1000;  bias_mem[1] = 16'hFC18;
        applyStimulus(2, 2, 1000, 0, -1);
        checkOutput("c3_nwrites", 64'(wq.size()), 64'd1);
`ifdef RELU_EN
        checkOutput("c3_word", wordAt(0), 64'h0000_0000_03E3_7FFF);
`else
        checkOutput("c3_word", wordAt(0), 64'hFD44_8000_03E3_7FFF);
`endif
        checkOutput("c3_wcyc", 64'(cycAt(0)), 64'd10);
        checkOutput("c3_done_cyc", 64'(done_cyc), 64'd11);

        // Case 4: FIFO full for cycles 5..24
        for (int i = 0; i < 16; i++) psum_mem[i] = 16'(i);
        bias_mem[0] = 16'h0010;
        applyStimulus(1, 16, 5, 20, -1);
        checkOutput("c4_nwrites", 64'(wq.size()), 64'd4);
        checkOutput("c4_word0", wordAt(0), 64'h0013_0012_0011_0010);
        checkOutput("c4_word1", wordAt(1), 64'h0017_0016_0015_0014);
        checkOutput("c4_word2", wordAt(2), 64'h001B_001A_0019_0018);
        checkOutput("c4_word3", wordAt(3), 64'h001F_001E_001D_001C);
        checkOutput("c4_we_while_full", 64'(full_we_err), 64'd0);
        checkOutput("c4_reads_by_24", 64'(rd_at24), 64'd7);
        checkOutput("c4_wcyc0", 64'(cycAt(0)), 64'd25);
        checkOutput("c4_wcyc3", 64'(cycAt(3)), 64'd36);
        checkOutput("c4_done_cyc", 64'(done_cyc), 64'd37);

        // Case 5: empty jobs
        applyStimulus(3, 0, 1000, 0, -1);
        checkOutput("c5a_done_cyc", 64'(done_cyc), 64'd2);
        checkOutput("c5a_psum_rds", 64'(rd_cnt), 64'd0);
        checkOutput("c5a_bias_rds", 64'(bq.size()), 64'd0);
        checkOutput("c5a_nwrites", 64'(wq.size()), 64'd0);
        checkOutput("c5a_busy_cycles", 64'(busy_cyc), 64'd1);
        applyStimulus(0, 5, 1000, 0, -1);
        checkOutput("c5b_done_cyc", 64'(done_cyc), 64'd2);
        checkOutput("c5b_nwrites", 64'(wq.size() + rd_cnt + bq.size()), 64'd0);

        // Case 6: reset in the middle of channel 1, then a clean rerun
        loadCase2();
        applyStimulus(2, 3, 1000, 0, 9);
        checkOutput("c6_abort_nwrites", 64'(wq.size()), 64'd0);
        checkOutput("c6_abort_done", 64'(done_cnt), 64'd0);
        applyStimulus(2, 3, 1000, 0, -1);
        checkCase2("c6");
        checkOutput("c6_done_cnt", 64'(done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
